// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared constants and load-FSM encoding for the programmable clock divider.
package clkdiv_pkg;

    localparam logic MODE_PULSE  = 1'b0;
    localparam logic MODE_SQUARE = 1'b1;
    localparam int   DIV_MIN     = 2;

    typedef enum logic {
        IDLE,
        PENDING
    } load_state_e;

endpackage

// File: rtl/div_reload_ctrl.sv
// div_reload_ctrl: load handshake that holds a requested ratio until the next period boundary.
module div_reload_ctrl
    import clkdiv_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wrap,
    input  logic             load,
    input  logic [WIDTH-1:0] div,
    output logic [WIDTH-1:0] div_active,
    output logic [WIDTH-1:0] div_next,
    output logic             apply,
    output logic             busy,
    output logic             load_ack,
    output logic             load_err
);

    load_state_e      state_q, state_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] act_q, act_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;

    // A frozen divider has no wrap to wait for, so a pending ratio lands on the next edge.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        apply   = (state_q == PENDING) && (wrap || !en);
        if (state_q == IDLE && load) begin
            if (div >= WIDTH'(DIV_MIN)) begin
                pend_d  = div;
                state_d = PENDING;
            end else begin
                err_d = 1'b1;
            end
        end
        if (apply) begin
            state_d = IDLE;
            ack_d   = 1'b1;
        end
        act_d = apply ? pend_q : act_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            act_q   <= WIDTH'(DEFAULT_DIV);
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            act_q   <= act_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign div_active = act_q;
    assign div_next   = act_d;
    assign busy       = (state_q == PENDING);
    assign load_ack   = ack_q;
    assign load_err   = err_q;

endmodule

// File: rtl/prog_clock_divider.sv
// prog_clock_divider: runtime-programmable clock divider producing TICK/STROBE enables and a
// pulse- or square-shaped CLK_OUT, all registered in the CLK domain.
module prog_clock_divider
    import clkdiv_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             MODE,
    input  logic [WIDTH-1:0] DIV,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] TAP,
    output logic             BUSY,
    output logic             LOAD_ACK,
    output logic             LOAD_ERR,
    output logic             CLK_OUT,
    output logic             TICK,
    output logic             STROBE,
    output logic [WIDTH-1:0] COUNT
);

    if (DEFAULT_DIV < DIV_MIN || DEFAULT_DIV > (2 ** WIDTH) - 1) begin : g_bad_default
        $error("prog_clock_divider: DEFAULT_DIV out of range");
    end

    logic             wrap, apply;
    logic [WIDTH-1:0] div_active, div_next;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   half;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             strobe_q, strobe_d;

    div_reload_ctrl #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_reload (
        .clk        (CLK),
        .rst        (RST),
        .en         (EN),
        .wrap       (wrap),
        .load       (LOAD),
        .div        (DIV),
        .div_active (div_active),
        .div_next   (div_next),
        .apply      (apply),
        .busy       (BUSY),
        .load_ack   (LOAD_ACK),
        .load_err   (LOAD_ERR)
    );

    // Square-mode threshold uses the ratio in force after this edge, widened so 2^WIDTH-1 cannot overflow.
    always_comb begin
        wrap      = EN && (cnt_q == div_active - WIDTH'(1));
        cnt_d     = (wrap || apply) ? '0 : cnt_q + WIDTH'(EN);
        half      = ({1'b0, div_next} + (WIDTH + 1)'(1)) >> 1;
        tick_d    = wrap;
        clk_out_d = !EN ? clk_out_q : (MODE == MODE_SQUARE) ? ({1'b0, cnt_d} < half) : wrap;
        strobe_d  = EN && (cnt_d == TAP);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            strobe_q  <= strobe_d;
        end
    end

    assign COUNT   = cnt_q;
    assign CLK_OUT = clk_out_q;
    assign TICK    = tick_q;
    assign STROBE  = strobe_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// tb_prog_clock_divider: directed checks of ratio loading, output shapes, enable freeze and reset.
module tb_prog_clock_divider;

    logic        CLK = 1'b0;
    logic        RST, EN, MODE, LOAD;
    logic [15:0] DIV, TAP;
    logic        BUSY, LOAD_ACK, LOAD_ERR, CLK_OUT, TICK, STROBE;
    logic [15:0] COUNT;
    int          n_chk = 0;
    int          n_fail = 0;

    prog_clock_divider #(.WIDTH(16), .DEFAULT_DIV(4)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .DIV(DIV), .LOAD(LOAD), .TAP(TAP),
        .BUSY(BUSY), .LOAD_ACK(LOAD_ACK), .LOAD_ERR(LOAD_ERR), .CLK_OUT(CLK_OUT),
        .TICK(TICK), .STROBE(STROBE), .COUNT(COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic step_chk(input int c, input logic t, input logic co);
        step();
        chk("count", COUNT, c);
        chk("tick", TICK, t);
        chk("clk_out", CLK_OUT, co);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_count", COUNT, 0);
        chk("rst_tick", TICK, 0);
        chk("rst_clk_out", CLK_OUT, 0);
        chk("rst_strobe", STROBE, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_ack", LOAD_ACK, 0);
        chk("rst_err", LOAD_ERR, 0);
    endtask

    initial begin
        RST = 1'b1; EN = 1'b1; MODE = 1'b0; LOAD = 1'b0; DIV = 16'd0; TAP = 16'd7;
        #1;
        chk_reset_outputs();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        // default ratio 4 in pulse mode; TAP=7 never strobes
        for (int e = 1; e <= 12; e++) begin
            step_chk(e % 4, (e % 4) == 0, (e % 4) == 0);
            chk("strobe_tap7", STROBE, 0);
        end
        TAP = 16'd2;
        for (int e = 1; e <= 8; e++) begin
            step_chk(e % 4, (e % 4) == 0, (e % 4) == 0);
            chk("strobe_tap2", STROBE, (e % 4) == 2);
        end
        // freeze right after a wrap: CLK_OUT must hold high, TAP=0 must not strobe
        EN = 1'b0; TAP = 16'd0;
        for (int e = 0; e < 3; e++) begin
            step_chk(0, 0, 1);
            chk("strobe_frozen", STROBE, 0);
        end
        EN = 1'b1; TAP = 16'd7;
        step_chk(1, 0, 0);
        // load 6 at cnt=1; further loads while busy are ignored
        LOAD = 1'b1; DIV = 16'd6;
        step_chk(2, 0, 0);
        chk("busy_6", BUSY, 1);
        DIV = 16'd9;
        step_chk(3, 0, 0);
        chk("busy_6b", BUSY, 1);
        DIV = 16'd0;
        step_chk(0, 1, 1);
        chk("ack_6", LOAD_ACK, 1);
        chk("busy_6_done", BUSY, 0);
        chk("err_ignored", LOAD_ERR, 0);
        LOAD = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step_chk(k % 6, (k % 6) == 0, (k % 6) == 0);
            chk("ack_6_quiet", LOAD_ACK, 0);
        end
        // back to 4, then square mode
        LOAD = 1'b1; DIV = 16'd4;
        step_chk(1, 0, 0);
        LOAD = 1'b0;
        for (int k = 2; k <= 5; k++) step_chk(k, 0, 0);
        step_chk(0, 1, 1);
        chk("ack_4", LOAD_ACK, 1);
        MODE = 1'b1;
        for (int k = 1; k <= 8; k++) step_chk(k % 4, (k % 4) == 0, (k % 4) < 2);
        step_chk(1, 0, 1);
        step_chk(2, 0, 0);
        step_chk(3, 0, 0);
        // load coincident with a wrap applies at the following wrap
        LOAD = 1'b1; DIV = 16'd5;
        step_chk(0, 1, 1);
        chk("busy_5", BUSY, 1);
        chk("ack_not_same_wrap", LOAD_ACK, 0);
        LOAD = 1'b0;
        step_chk(1, 0, 1);
        step_chk(2, 0, 0);
        step_chk(3, 0, 0);
        step_chk(0, 1, 1);
        chk("ack_5", LOAD_ACK, 1);
        for (int k = 1; k <= 10; k++) step_chk(k % 5, (k % 5) == 0, (k % 5) < 3);
        // rejected ratios
        LOAD = 1'b1; DIV = 16'd1;
        step_chk(1, 0, 1);
        chk("err_div1", LOAD_ERR, 1);
        chk("busy_div1", BUSY, 0);
        DIV = 16'd0;
        step_chk(2, 0, 1);
        chk("err_div0", LOAD_ERR, 1);
        chk("busy_div0", BUSY, 0);
        LOAD = 1'b0;
        step_chk(3, 0, 0);
        chk("err_clear", LOAD_ERR, 0);
        step_chk(4, 0, 0);
        step_chk(0, 1, 1);
        // pending ratio applied while frozen
        LOAD = 1'b1; DIV = 16'd4;
        step_chk(1, 0, 1);
        chk("busy_frz", BUSY, 1);
        LOAD = 1'b0; EN = 1'b0;
        step_chk(0, 0, 1);
        chk("ack_frz", LOAD_ACK, 1);
        chk("busy_frz_done", BUSY, 0);
        EN = 1'b1; MODE = 1'b0;
        step_chk(1, 0, 0);
        step_chk(2, 0, 0);
        step_chk(3, 0, 0);
        step_chk(0, 1, 1);
        // async reset while a load is pending
        LOAD = 1'b1; DIV = 16'd9;
        step_chk(1, 0, 0);
        LOAD = 1'b0;
        chk("busy_9", BUSY, 1);
        #2;
        RST = 1'b1;
        #1;
        chk_reset_outputs();
        @(negedge CLK);
        RST = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step_chk(e % 4, (e % 4) == 0, (e % 4) == 0);
            chk("ack_after_rst", LOAD_ACK, 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
